// File: rtl/rocstar_mcu_link.sv
// rocstar_mcu_link: nibble command link from the MCU plus single-hit reports back to it.
// Decodes idle-state command nibbles into one-cycle pulses and run-enable, assembles
// 16-bit words framed by nibble 8, counts bad nibbles, singles and coincidences, and
// measures single-to-answer latency.
// Optional feature: define ROCSTAR_TESTPATT_EN to let do_testp send testpatt on to_mcu.
module rocstar_mcu_link (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  from_mcu,
  output logic [7:0]  to_mcu,
  input  logic        single,
  input  logic [5:0]  offset,
  input  logic [7:0]  testpatt,
  input  logic        do_testp,
  output logic [15:0] spword,
  output logic        runmode,
  output logic        sync_clk,
  output logic        save_clk,
  output logic        pcoinc,
  output logic        dcoinc,
  output logic        ncoinc,
  output logic [15:0] badidle,
  output logic [15:0] numsingl,
  output logic [15:0] numcoinc,
  output logic [7:0]  latency
);

  typedef enum logic [2:0] {StIdle, StW3, StW2, StW1, StW0} state_e;

  state_e      state_q, state_d;
  logic [11:0] shift_q, shift_d;
  logic [15:0] spword_d;
  logic        runmode_d;
  logic        sync_d, save_d, pcoinc_d, dcoinc_d, ncoinc_d;
  logic        bad_nib;
  logic        answer;
  logic        testp_sel;
  logic        send_single;
  logic [7:0]  to_mcu_d;
  logic [7:0]  lat_cnt_q;
  logic        outstanding_q;

`ifdef ROCSTAR_TESTPATT_EN
  assign testp_sel = do_testp;
`else
  // Test-pattern inputs have no function in this build.
  logic unused_testp;
  assign unused_testp = ^{do_testp, testpatt};
  assign testp_sel    = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM next state: nibble 8 opens a frame of four data nibbles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (from_mcu == 4'h8) state_d = StW3;
      StW3:    state_d = StW2;
      StW2:    state_d = StW1;
      StW1:    state_d = StW0;
      StW0:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: command decode in idle, data capture inside a frame.
  always_comb begin
    sync_d    = 1'b0;
    save_d    = 1'b0;
    pcoinc_d  = 1'b0;
    dcoinc_d  = 1'b0;
    ncoinc_d  = 1'b0;
    bad_nib   = 1'b0;
    runmode_d = runmode;
    spword_d  = spword;
    shift_d   = shift_q;
    case (state_q)
      StIdle: begin
        case (from_mcu)
          4'h0:    ;
          4'h1:    pcoinc_d  = 1'b1;
          4'h2:    dcoinc_d  = 1'b1;
          4'h3:    ncoinc_d  = 1'b1;
          4'h4:    sync_d    = 1'b1;
          4'h5:    save_d    = 1'b1;
          4'h6:    runmode_d = 1'b1;
          4'h7:    runmode_d = 1'b0;
          4'h8:    ;
          default: bad_nib   = 1'b1;
        endcase
      end
      StW3:    shift_d[11:8] = from_mcu;
      StW2:    shift_d[7:4]  = from_mcu;
      StW1:    shift_d[3:0]  = from_mcu;
      StW0:    spword_d      = {shift_q, from_mcu};
      default: ;
    endcase
  end

  assign answer      = pcoinc_d | dcoinc_d | ncoinc_d;
  assign send_single = single & runmode & ~testp_sel;

  // Report byte: test pattern wins, then a single report, else idle zero.
  always_comb begin
    to_mcu_d = 8'h00;
    if (testp_sel)        to_mcu_d = testpatt;
    else if (send_single) to_mcu_d = {2'b10, offset};
  end

  // Registered link outputs and frame shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q  <= '0;
      spword   <= '0;
      runmode  <= 1'b0;
      sync_clk <= 1'b0;
      save_clk <= 1'b0;
      pcoinc   <= 1'b0;
      dcoinc   <= 1'b0;
      ncoinc   <= 1'b0;
      to_mcu   <= '0;
    end else begin
      shift_q  <= shift_d;
      spword   <= spword_d;
      runmode  <= runmode_d;
      sync_clk <= sync_d;
      save_clk <= save_d;
      pcoinc   <= pcoinc_d;
      dcoinc   <= dcoinc_d;
      ncoinc   <= ncoinc_d;
      to_mcu   <= to_mcu_d;
    end
  end

  // Statistics: saturating bad-nibble count, wrapping single and coincidence counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      badidle  <= '0;
      numsingl <= '0;
      numcoinc <= '0;
    end else begin
      if (bad_nib && badidle != 16'hFFFF) badidle <= badidle + 16'd1;
      if (send_single)                    numsingl <= numsingl + 16'd1;
      if (pcoinc_d || dcoinc_d)           numcoinc <= numcoinc + 16'd1;
    end
  end

  // Latency: capture on the first answer after a single, then restart for a new single.
  always_ff @(posedge clk) begin
    if (rst) begin
      latency       <= '0;
      lat_cnt_q     <= '0;
      outstanding_q <= 1'b0;
    end else begin
      if (answer && outstanding_q) latency <= lat_cnt_q;
      if (send_single) begin
        lat_cnt_q     <= '0;
        outstanding_q <= 1'b1;
      end else begin
        if (answer)              outstanding_q <= 1'b0;
        if (lat_cnt_q != 8'hFF)  lat_cnt_q     <= lat_cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_rocstar_mcu_link.sv
// Directed table-driven bench for rocstar_mcu_link, plus hand sequences for
// reset-time input masking and latency saturation.
module tb_rocstar_mcu_link;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  from_mcu;
  logic [7:0]  to_mcu;
  logic        single;
  logic [5:0]  offset;
  logic [7:0]  testpatt;
  logic        do_testp;
  logic [15:0] spword;
  logic        runmode;
  logic        sync_clk, save_clk, pcoinc, dcoinc, ncoinc;
  logic [15:0] badidle, numsingl, numcoinc;
  logic [7:0]  latency;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rocstar_mcu_link dut (
    .clk      (clk),
    .rst      (rst),
    .from_mcu (from_mcu),
    .to_mcu   (to_mcu),
    .single   (single),
    .offset   (offset),
    .testpatt (testpatt),
    .do_testp (do_testp),
    .spword   (spword),
    .runmode  (runmode),
    .sync_clk (sync_clk),
    .save_clk (save_clk),
    .pcoinc   (pcoinc),
    .dcoinc   (dcoinc),
    .ncoinc   (ncoinc),
    .badidle  (badidle),
    .numsingl (numsingl),
    .numcoinc (numcoinc),
    .latency  (latency)
  );

  // Packed view: to_mcu, pulses{sync,save,p,d,n}, runmode, spword, badidle, numsingl,
  // numcoinc, latency.
  typedef logic [85:0] obs_t;

  typedef struct {
    logic       r;
    logic [3:0] fm;
    logic       sg;
    logic [5:0] off;
    logic       dt;
    logic [7:0] tp;
    obs_t       exp;
  } vec_t;

  vec_t vecs[$];

  function automatic obs_t ex(input logic [7:0] tm, input logic [4:0] pl, input logic rm,
                              input logic [15:0] sw, input logic [15:0] bi,
                              input logic [15:0] ns, input logic [15:0] nc,
                              input logic [7:0] lt);
    return {tm, pl, rm, sw, bi, ns, nc, lt};
  endfunction

  function automatic obs_t observe();
    return {to_mcu, sync_clk, save_clk, pcoinc, dcoinc, ncoinc, runmode, spword, badidle,
            numsingl, numcoinc, latency};
  endfunction

  task automatic add(input logic r, input logic [3:0] fm, input logic sg,
                     input logic [5:0] off, input logic dt, input logic [7:0] tp,
                     input obs_t e);
    vecs.push_back('{r: r, fm: fm, sg: sg, off: off, dt: dt, tp: tp, exp: e});
  endtask

  task automatic drive(input logic r, input logic [3:0] fm, input logic sg,
                       input logic [5:0] off, input logic dt, input logic [7:0] tp);
    rst = r; from_mcu = fm; single = sg; offset = off; do_testp = dt; testpatt = tp;
    @(posedge clk);
    #1;
  endtask

  task automatic check_obs(input string name, input obs_t got, input obs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got tm=%h pl=%b rm=%b sw=%h bi=%h ns=%h nc=%h lt=%h, want tm=%h pl=%b rm=%b sw=%h bi=%h ns=%h nc=%h lt=%h",
               name, got[85:78], got[77:73], got[72], got[71:56], got[55:40], got[39:24],
               got[23:8], got[7:0], want[85:78], want[77:73], want[72], want[71:56],
               want[55:40], want[39:24], want[23:8], want[7:0]);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    // Frame, commands, bad nibbles.
    add(0, 4'h6, 0, 0, 0, 0, ex(8'h00, 5'b00000, 1, 16'h0000, 0, 0, 0, 0));
    add(0, 4'h7, 0, 0, 0, 0, ex(8'h00, 5'b00000, 0, 16'h0000, 0, 0, 0, 0));
    add(0, 4'h0, 0, 0, 0, 0, ex(8'h00, 5'b00000, 0, 16'h0000, 0, 0, 0, 0));
    add(0, 4'h8, 0, 0, 0, 0, ex(8'h00, 5'b00000, 0, 16'h0000, 0, 0, 0, 0));
    add(0, 4'hA, 0, 0, 0, 0, ex(8'h00, 5'b00000, 0, 16'h0000, 0, 0, 0, 0));
    add(0, 4'hB, 0, 0, 0, 0, ex(8'h00, 5'b00000, 0, 16'h0000, 0, 0, 0, 0));
    add(0, 4'hC, 0, 0, 0, 0, ex(8'h00, 5'b00000, 0, 16'h0000, 0, 0, 0, 0));
    add(0, 4'hD, 0, 0, 0, 0, ex(8'h00, 5'b00000, 0, 16'hABCD, 0, 0, 0, 0));
    add(0, 4'h4, 0, 0, 0, 0, ex(8'h00, 5'b10000, 0, 16'hABCD, 0, 0, 0, 0));
    add(0, 4'h5, 0, 0, 0, 0, ex(8'h00, 5'b01000, 0, 16'hABCD, 0, 0, 0, 0));
    add(0, 4'h1, 0, 0, 0, 0, ex(8'h00, 5'b00100, 0, 16'hABCD, 0, 0, 1, 0));
    add(0, 4'h2, 0, 0, 0, 0, ex(8'h00, 5'b00010, 0, 16'hABCD, 0, 0, 2, 0));
    add(0, 4'h3, 0, 0, 0, 0, ex(8'h00, 5'b00001, 0, 16'hABCD, 0, 0, 2, 0));
    add(0, 4'h9, 0, 0, 0, 0, ex(8'h00, 5'b00000, 0, 16'hABCD, 1, 0, 2, 0));
    add(0, 4'hF, 0, 0, 0, 0, ex(8'h00, 5'b00000, 0, 16'hABCD, 2, 0, 2, 0));
    add(0, 4'hF, 0, 0, 0, 0, ex(8'h00, 5'b00000, 0, 16'hABCD, 3, 0, 2, 0));
    // Reset mid-frame after 8,1; the next nibble must decode as a command.
    add(0, 4'h8, 0, 0, 0, 0, ex(8'h00, 5'b00000, 0, 16'hABCD, 3, 0, 2, 0));
    add(0, 4'h1, 0, 0, 0, 0, ex(8'h00, 5'b00000, 0, 16'hABCD, 3, 0, 2, 0));
    add(1, 4'h6, 1, 6'h15, 0, 0, ex(8'h00, 5'b00000, 0, 16'h0000, 0, 0, 0, 0));
    add(0, 4'h4, 0, 0, 0, 0, ex(8'h00, 5'b10000, 0, 16'h0000, 0, 0, 0, 0));
    add(0, 4'h5, 0, 0, 0, 0, ex(8'h00, 5'b01000, 0, 16'h0000, 0, 0, 0, 0));
    add(0, 4'h0, 0, 0, 0, 0, ex(8'h00, 5'b00000, 0, 16'h0000, 0, 0, 0, 0));
    // Single ignored while runmode is still 0, then a real single.
    add(0, 4'h6, 1, 6'h15, 0, 0, ex(8'h00, 5'b00000, 1, 16'h0000, 0, 0, 0, 0));
    add(0, 4'h0, 1, 6'h15, 0, 0, ex(8'h95, 5'b00000, 1, 16'h0000, 0, 1, 0, 0));
    for (int i = 0; i < 10; i++)
      add(0, 4'h0, 0, 0, 0, 0, ex(8'h00, 5'b00000, 1, 16'h0000, 0, 1, 0, 0));
    add(0, 4'h1, 0, 0, 0, 0, ex(8'h00, 5'b00100, 1, 16'h0000, 0, 1, 1, 8'd10));
    // Answer with nothing outstanding keeps latency.
    add(0, 4'h2, 0, 0, 0, 0, ex(8'h00, 5'b00010, 1, 16'h0000, 0, 1, 2, 8'd10));
    // Single and answer in the same cycle: old count captured, counter restarted.
    add(0, 4'h0, 1, 6'h3F, 0, 0, ex(8'hBF, 5'b00000, 1, 16'h0000, 0, 2, 2, 8'd10));
    add(0, 4'h0, 0, 0, 0, 0, ex(8'h00, 5'b00000, 1, 16'h0000, 0, 2, 2, 8'd10));
    add(0, 4'h3, 1, 6'h00, 0, 0, ex(8'h80, 5'b00001, 1, 16'h0000, 0, 3, 2, 8'd1));
    add(0, 4'h0, 0, 0, 0, 0, ex(8'h00, 5'b00000, 1, 16'h0000, 0, 3, 2, 8'd1));
    add(0, 4'h0, 0, 0, 0, 0, ex(8'h00, 5'b00000, 1, 16'h0000, 0, 3, 2, 8'd1));
    add(0, 4'h2, 0, 0, 0, 0, ex(8'h00, 5'b00010, 1, 16'h0000, 0, 3, 3, 8'd2));
    add(0, 4'h1, 0, 0, 0, 0, ex(8'h00, 5'b00100, 1, 16'h0000, 0, 3, 4, 8'd2));
`ifdef ROCSTAR_TESTPATT_EN
    add(0, 4'h0, 1, 6'h15, 1, 8'h5A, ex(8'h5A, 5'b00000, 1, 16'h0000, 0, 3, 4, 8'd2));
    add(0, 4'h7, 0, 0, 0, 0, ex(8'h00, 5'b00000, 0, 16'h0000, 0, 3, 4, 8'd2));
    add(0, 4'h0, 1, 6'h01, 1, 8'hC3, ex(8'hC3, 5'b00000, 0, 16'h0000, 0, 3, 4, 8'd2));
`else
    add(0, 4'h0, 1, 6'h15, 1, 8'h5A, ex(8'h95, 5'b00000, 1, 16'h0000, 0, 4, 4, 8'd2));
    add(0, 4'h7, 0, 0, 0, 0, ex(8'h00, 5'b00000, 0, 16'h0000, 0, 4, 4, 8'd2));
    add(0, 4'h0, 1, 6'h01, 1, 8'hC3, ex(8'h00, 5'b00000, 0, 16'h0000, 0, 4, 4, 8'd2));
`endif

    // Reset with active inputs must leave everything cleared.
    drive(1, 4'h6, 1, 6'h15, 1, 8'h5A);
    drive(1, 4'h6, 1, 6'h15, 1, 8'h5A);
    check_obs("reset", observe(), '0);

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].fm, vecs[i].sg, vecs[i].off, vecs[i].dt, vecs[i].tp);
      check_obs($sformatf("vec%0d", i), observe(), vecs[i].exp);
    end

    // Latency saturates at 255 for a long wait.
    drive(0, 4'h6, 0, 0, 0, 0);
    check_val("sat_runmode", 32'(runmode), 32'd1);
    drive(0, 4'h0, 1, 6'h00, 0, 0);
    check_val("sat_single_byte", 32'(to_mcu), 32'h80);
    for (int i = 0; i < 300; i++) drive(0, 4'h0, 0, 0, 0, 0);
    check_val("sat_byte_idle", 32'(to_mcu), 32'h00);
    drive(0, 4'h3, 0, 0, 0, 0);
    check_val("sat_ncoinc", 32'(ncoinc), 32'd1);
    check_val("sat_latency", 32'(latency), 32'hFF);
    drive(0, 4'h0, 0, 0, 0, 0);
    check_val("sat_ncoinc_one_cycle", 32'(ncoinc), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rocstar_mcu_link.md
ROCSTAR_MCU_LINK -- requirements
Module: rocstar_mcu_link

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: from_mcu  in  4  command nibble stream from MCU.
REQ-004 SHALL have ports: to_mcu  out  8  report byte stream to MCU.
REQ-005 SHALL have ports: single  in  1  local single-hit strobe (one cycle per hit).
REQ-006 SHALL have ports: offset  in  6  fine-time offset of the hit, sampled with single.
REQ-007 SHALL have ports: testpatt  in  8  test byte; do_testp  in  1  send test byte instead of normal traffic.
REQ-008 SHALL have ports: spword  out  16  last serial-parallel word received; runmode  out  1  run-enable level.
REQ-009 SHALL have ports: sync_clk, save_clk, pcoinc, dcoinc, ncoinc  out  1 each  one-cycle pulses.
REQ-010 SHALL have ports: badidle  out  16  bad-code count; numsingl  out  16  singles sent; numcoinc  out  16  coincidences received; latency  out  8  single-to-answer cycles.

Function
REQ-011 SHALL register all outputs; from_mcu sampled at edge n produces its pulse/level change in cycle n+1, lasting exactly one cycle for pulses.
REQ-012 SHALL decode idle-state nibbles: 0 idle; 1 pcoinc; 2 dcoinc; 3 ncoinc; 4 sync_clk; 5 save_clk; 6 runmode<=1; 7 runmode<=0; 8 start of word frame; 9..F bad.
REQ-013 SHALL, after nibble 8, take the next 4 nibbles as data MS-nibble first, with no command decoding; spword updates in the cycle after the 4th data nibble; FSM states IDLE, W3, W2, W1, W0 -> IDLE.
REQ-014 SHALL increment badidle on each bad nibble in IDLE, saturating at 16'hFFFF.
REQ-015 SHALL increment numcoinc on each pcoinc or dcoinc (not ncoinc), wrapping modulo 2^16.
REQ-016 SHALL, with single=1, runmode=1 and do_testp=0 at edge n, drive to_mcu={1'b1,1'b0,offset} in cycle n+1 only and increment numsingl (wrapping); else to_mcu=8'h00.
REQ-017 SHALL ignore single while runmode=0 (no byte, no count).
REQ-018 SHALL, when a single is sent, restart an internal latency counter at 0, incrementing each cycle, saturating at 255.
REQ-019 SHALL, on the next pcoinc/dcoinc/ncoinc after a sent single, copy the counter value into latency and mark no single outstanding; answers with none outstanding leave latency unchanged.
REQ-020 SHALL, when single and answer coincide in one cycle, capture latency first, then restart the counter for the new single.

Reset
REQ-021 SHALL on rst=1: to_mcu=0, spword=0, runmode=0, all pulses 0, badidle=numsingl=numcoinc=0, latency=0, FSM to IDLE (aborting any partial frame), no single outstanding.
REQ-022 SHALL ignore from_mcu, single and do_testp during the reset cycle.

Configuration
REQ-023 SHALL with ROCSTAR_TESTPATT_EN defined: do_testp=1 at edge n drives to_mcu=testpatt in cycle n+1, overriding and discarding any single (not counted), regardless of runmode.
REQ-024 SHALL without ROCSTAR_TESTPATT_EN: do_testp and testpatt ignored; to_mcu carries only single reports.

Verification
REQ-025 SHALL test: rst then from_mcu=6 one cycle -> runmode=1 next cycle; then 7 -> runmode=0.
REQ-026 SHALL test: nibbles 8,A,B,C,D -> spword=16'hABCD one cycle after D; no pulses, badidle unchanged.
REQ-027 SHALL test: nibbles 4,5,1,2,3 -> one-cycle sync_clk, save_clk, pcoinc, dcoinc, ncoinc in order; numcoinc=2.
REQ-028 SHALL test: nibbles 9,F,F -> badidle=3; rst mid-frame (after 8,1) -> spword stays 0, next 4 decoded as sync_clk.
REQ-029 SHALL test: runmode=1, single with offset=6'h15 -> to_mcu=8'h95 one cycle, numsingl=1; pcoinc 10 cycles later -> latency=10.
REQ-030 SHALL test (macro defined): do_testp=1, testpatt=8'h5A with single=1 -> to_mcu=8'h5A, numsingl unchanged.
